// File: rtl/tx_ds_seq.sv
// Transmit character sequencer: arbitrates time-codes, FCTs, N-chars and NULL fill onto the encoder; 1-cycle registered issue.
// Backpressure: a character is issued only when ready_i is high and no request was made in the previous cycle.
module tx_ds_seq #(
    parameter int FCT_PEND_MAX = 7,
    parameter int CREDIT_MAX   = 56
) (
    input  logic       TxClk,
    input  logic       TxReset_n,
    input  logic       en_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] dat_o,
    output logic       lchar_o,
    input  logic       fct_req_i,
    input  logic       tick_i,
    input  logic [7:0] time_i,
    input  logic       dvalid_i,
    input  logic [8:0] ddat_i,
    output logic       dready_o,
    input  logic       fct_rx_i,
    output logic [5:0] credit_o,
    output logic       credit_err_o
);

    typedef enum logic {IDLE, SECOND} state_t;

    localparam logic [1:0] C_FCT = 2'b00;
    localparam logic [1:0] C_EEP = 2'b01;
    localparam logic [1:0] C_EOP = 2'b10;
    localparam logic [1:0] C_ESC = 2'b11;

    state_t     state_q;
    logic       valid_q, lchar_q, dready_q, credit_err_q;
    logic [7:0] dat_q;
    logic [7:0] second_dat_q;
    logic       second_lchar_q;
    logic       tick_pend_q;
    logic [7:0] time_q;
    logic [2:0] fct_pend_q, fct_pend_d;
    logic [5:0] credit_q, credit_d;
    logic       credit_err_d;
    logic [6:0] credit_net, credit_add;

    logic issue_ok, idle_go, sel_tick, sel_fct, sel_data, sel_null;

    assign issue_ok = ready_i && !valid_q;
    assign idle_go  = issue_ok && (state_q == IDLE) && en_i;
    assign sel_tick = idle_go && tick_pend_q;
    assign sel_fct  = idle_go && !tick_pend_q && (fct_pend_q != 3'd0);
    assign sel_data = idle_go && !tick_pend_q && (fct_pend_q == 3'd0) && dvalid_i && (credit_q != 6'd0);
    assign sel_null = idle_go && !tick_pend_q && (fct_pend_q == 3'd0) && !(dvalid_i && (credit_q != 6'd0));

    // A request and an FCT issue in the same cycle cancel; requests at saturation are dropped.
    always_comb begin
        fct_pend_d = fct_pend_q;
        if (fct_req_i && !sel_fct && (fct_pend_q != 3'(FCT_PEND_MAX))) begin
            fct_pend_d = fct_pend_q + 3'd1;
        end else if (!fct_req_i && sel_fct) begin
            fct_pend_d = fct_pend_q - 3'd1;
        end
    end

    // Overflow is judged on the credit left after this cycle's consume.
    always_comb begin
        credit_net   = {1'b0, credit_q} - {6'd0, sel_data};
        credit_add   = credit_net + 7'd8;
        credit_err_d = fct_rx_i && (credit_add > 7'(CREDIT_MAX));
        credit_d     = (fct_rx_i && !credit_err_d) ? credit_add[5:0] : credit_net[5:0];
    end

    always_ff @(posedge TxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            state_q        <= IDLE;
            valid_q        <= 1'b0;
            dat_q          <= 8'd0;
            lchar_q        <= 1'b0;
            dready_q       <= 1'b0;
            credit_err_q   <= 1'b0;
            credit_q       <= 6'd0;
            fct_pend_q     <= 3'd0;
            tick_pend_q    <= 1'b0;
            time_q         <= 8'd0;
            second_dat_q   <= 8'd0;
            second_lchar_q <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            dready_q     <= 1'b0;
            credit_err_q <= credit_err_d;
            credit_q     <= credit_d;
            fct_pend_q   <= fct_pend_d;

            // A tick arriving as the ESC goes out queues a fresh time-code.
            if (tick_i) begin
                tick_pend_q <= 1'b1;
                time_q      <= time_i;
            end else if (sel_tick) begin
                tick_pend_q <= 1'b0;
            end

            if (issue_ok && (state_q == SECOND)) begin
                valid_q <= 1'b1;
                dat_q   <= second_dat_q;
                lchar_q <= second_lchar_q;
                state_q <= IDLE;
            end else if (sel_tick) begin
                valid_q        <= 1'b1;
                dat_q          <= {6'd0, C_ESC};
                lchar_q        <= 1'b1;
                second_dat_q   <= time_q;
                second_lchar_q <= 1'b0;
                state_q        <= SECOND;
            end else if (sel_fct) begin
                valid_q <= 1'b1;
                dat_q   <= {6'd0, C_FCT};
                lchar_q <= 1'b1;
            end else if (sel_data) begin
                valid_q  <= 1'b1;
                dready_q <= 1'b1;
                if (ddat_i[8]) begin
                    dat_q   <= {6'd0, (ddat_i[0] ? C_EEP : C_EOP)};
                    lchar_q <= 1'b1;
                end else begin
                    dat_q   <= ddat_i[7:0];
                    lchar_q <= 1'b0;
                end
            end else if (sel_null) begin
                valid_q        <= 1'b1;
                dat_q          <= {6'd0, C_ESC};
                lchar_q        <= 1'b1;
                second_dat_q   <= {6'd0, C_FCT};
                second_lchar_q <= 1'b1;
                state_q        <= SECOND;
            end
        end
    end

    assign valid_o      = valid_q;
    assign dat_o        = dat_q;
    assign lchar_o      = lchar_q;
    assign dready_o     = dready_q;
    assign credit_o     = credit_q;
    assign credit_err_o = credit_err_q;

endmodule
